// File: rtl/divider_32by16.sv
// Iterative unsigned restoring divider, one quotient bit per clk; done 32 edges after an accepted start (divide-by-zero: same edge).
// No backpressure: start_in is only sampled in IDLE, and results hold until the next accepted start completes.
module divider_32by16 #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [DIVIDEND_W-1:0] dividend_in,
  input  logic [DIVISOR_W-1:0]  divisor_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [DIVIDEND_W-1:0] quotient_out,
  output logic [DIVISOR_W-1:0]  remainder_out,
  output logic                  div_by_zero_out
);

  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] shift_q, shift_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_d, done_d, dbz_d;
  logic [DIVIDEND_W-1:0] quot_d;
  logic [DIVISOR_W-1:0]  remo_d;

  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W:0]    rem_sub;
  logic                  rem_ge;

  // The partial remainder's top bit is always 0 between steps, so shifting it out is lossless.
  assign rem_shift = (rem_q << 1) | {{DIVISOR_W{1'b0}}, shift_q[DIVIDEND_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr_q});
  assign rem_sub   = rem_shift - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = div_by_zero_out;
    quot_d  = quotient_out;
    remo_d  = remainder_out;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (divisor_in != '0) begin
            dvsr_d  = divisor_in;
            rem_d   = '0;
            shift_d = dividend_in;
            cnt_d   = CW'(DIVIDEND_W - 1);
            state_d = CALC;
          end else begin
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quot_d  = '1;
            remo_d  = dividend_in[DIVISOR_W-1:0];
          end
        end
      end
      CALC: begin
        shift_d = {shift_q[DIVIDEND_W-2:0], rem_ge};
        rem_d   = rem_ge ? rem_sub : rem_shift;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          quot_d  = shift_d;
          remo_d  = rem_d[DIVISOR_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      rem_q           <= '0;
      dvsr_q          <= '0;
      cnt_q           <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      div_by_zero_out <= 1'b0;
      quotient_out    <= '0;
      remainder_out   <= '0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      rem_q           <= rem_d;
      dvsr_q          <= dvsr_d;
      cnt_q           <= cnt_d;
      busy_out        <= busy_d;
      done_out        <= done_d;
      div_by_zero_out <= dbz_d;
      quotient_out    <= quot_d;
      remainder_out   <= remo_d;
    end
  end

endmodule
